alu: RTL and testbench
======================

# alu

Bit-serial, multi-cycle N-bit ALU. It performs add, subtract, AND, OR, NOT, logical shift left/right and an optional unsigned multiply. One result bit (or one shift/multiply step) is produced per clock. The block is a compact datapath unit for area-constrained designs, where N-cycle latency is acceptable in exchange for single-bit adder hardware.

## Interface
Parameters:
- N, default 4, operand/result width (N >= 2)

Ports (positional order for instantiation: inp, clk, opcode, a, b, y_ext, y, ovf, rst):
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- inp  in  1  start strobe; sampled high on a rising edge starts an operation
- opcode  in  3  operation select, captured at start
- a  in  N  operand A, captured at start
- b  in  N  operand B, captured at start
- y  out  N  result (low half for multiply)
- y_ext  out  N  high half of multiply product; 0 for all other ops
- ovf  out  1  add carry-out / subtract borrow; 0 for all other ops

## Operation
- Opcodes:
  - 000 add: {ovf,y} = a+b
  - 001 sub: y = (a-b) mod 2^N; ovf=1 when a<b (borrow)
  - 010 and: y = a&b
  - 011 or: y = a|b
  - 100 not: y = ~a
  - 101 shl: y = a<<k after step k
  - 110 shr: y = a>>k after step k (logical, zero fill)
  - 111 mul: {y_ext,y} = a*b, unsigned, 2N bits
- State: operand shift registers A,B; opcode register; carry flop; log2(N)+1-bit step counter; busy flag; result registers y, y_ext.
- Start (inp=1 at an edge, rst=0):
  - capture a, b, opcode; counter=N; busy=1; carry=0 (sub: carry=1, B inverted)
  - y=0, y_ext=0, ovf=0
  - shifts load y=a; mul loads y=b, y_ext=0
- Add/sub/logic step:
  - compute bit from A[0], B[0], carry
  - shift result bit into y MSB, shifting y right
  - shift A, B right; update carry
  - y is complete after N steps with LSB in y[0]
  - on the final step: ovf = carry-out (add) or ~carry-out (sub)
- Shift step: y shifted one position, zero fill.
- Mul step (shift-add):
  - if y[0]: {c,y_ext} = y_ext + A
  - then {c,y_ext,y} shifted right one position
- Counter decrements each step; at 0, busy=0 and outputs hold until the next start or reset.
- inp=1 while busy aborts the current operation and restarts with new operands.
- Intermediate y/y_ext values during busy are partial results, except shifts, where each step is a valid a<<k / a>>k.

## Timing
- Reset: y=0, y_ext=0, ovf=0, busy=0, counter=0; rst has priority over inp.
- Start edge is cycle 0. Steps occur at edges 1..N. Final result is visible after edge N (latency N cycles) and stable until the next start.
- Shifts: after edge k (1<=k<=N), y = a shifted by k. After edge N, y=0.
- inp held high for several edges restarts every edge; inp must be low after the start edge for the operation to complete.
- Inputs a, b, opcode are don't-care while busy.

## Configuration
- ALU_MUL_EN defined: opcode 111 performs the multiply above.
- ALU_MUL_EN undefined: multiply datapath is omitted. Opcode 111 still runs N cycles (busy behaviour unchanged) and ends with y=0, y_ext=0, ovf=0.

## Test plan
- N=4, a=5, b=13, op=000, start, wait 4 cycles -> ovf=1, y=0010 ({ovf,y}=18).
- a=5, b=13, op=001 -> y=1000 (signed -8), ovf=1. With a=13, b=5 -> y=1000 (8), ovf=0.
- a=5, b=13: op=010 -> y=0101. op=011 -> y=1101. op=100 -> y=1010. y_ext=0 and ovf=0 throughout.
- a=5, op=101, sample after edges 1..4 -> y=1010, 0100, 1000, 0000. Op=110 -> 0010, 0001, 0000, 0000.
- a=5, b=13, op=111 (ALU_MUL_EN) -> {y_ext,y}=0100_0001 (65) after 4 cycles. a=15, b=15 -> 1110_0001 (225).
- Assert rst mid-add (after 2 steps) -> next edge y=0, y_ext=0, ovf=0, idle. Start during busy -> result matches only the new operands after N cycles.

Source files
------------

// File: rtl/alu.sv
// alu -- bit-serial, multi-cycle N-bit ALU.
//
// Each operation takes N clock steps after its start edge. Add and subtract
// use a single full adder plus a carry flop. Logic ops produce one result bit
// per step. Shifts move y one position per step. Multiply is shift-add and
// yields a 2N-bit product in {y_ext, y}.
//
// Optional feature: define ALU_MUL_EN to build the multiply datapath. When it
// is not defined, opcode 111 still runs N busy cycles and ends with y=0,
// y_ext=0 and ovf=0.
//
// Ports:
//   inp     start strobe; a high sample on a rising edge starts (or restarts)
//           an operation, capturing opcode, a and b
//   clk     clock, rising edge
//   opcode  000 add, 001 sub, 010 and, 011 or, 100 not, 101 shl, 110 shr,
//           111 mul
//   a, b    N-bit operands
//   y_ext   high half of the multiply product, 0 for every other op
//   y       N-bit result (low half of the product for multiply)
//   ovf     add carry-out / subtract borrow, 0 for every other op
//   rst     synchronous active-high reset; has priority over inp
module alu #(
  parameter int N = 4
) (
  input  logic         inp,
  input  logic         clk,
  input  logic [2:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y_ext,
  output logic [N-1:0] y,
  output logic         ovf,
  input  logic         rst
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [2:0]    op_r;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          busy;

  logic [N-1:0]  y_nxt;
  logic [N-1:0]  y_ext_nxt;
  logic          carry_nxt;
  logic          res_bit;
  logic          last_step;
`ifdef ALU_MUL_EN
  logic [N:0]    mul_sum;
`endif

  function automatic logic fa_sum(input logic x, input logic z, input logic ci);
    return x ^ z ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic z, input logic ci);
    return (x & z) | (x & ci) | (z & ci);
  endfunction

  assign last_step = (cnt == CW'(1));

  // Step datapath: next value of y / y_ext / carry for the current opcode.
  always_comb begin
    y_nxt     = y;
    y_ext_nxt = y_ext;
    carry_nxt = carry;
    res_bit   = 1'b0;
`ifdef ALU_MUL_EN
    mul_sum   = '0;
`endif
    case (op_r)
      OP_ADD, OP_SUB: begin
        // Subtract was set up at start as a + ~b + 1.
        res_bit   = fa_sum(a_sr[0], b_sr[0], carry);
        carry_nxt = fa_carry(a_sr[0], b_sr[0], carry);
        y_nxt     = {res_bit, y[N-1:1]};
      end
      OP_AND: begin
        res_bit = a_sr[0] & b_sr[0];
        y_nxt   = {res_bit, y[N-1:1]};
      end
      OP_OR: begin
        res_bit = a_sr[0] | b_sr[0];
        y_nxt   = {res_bit, y[N-1:1]};
      end
      OP_NOT: begin
        res_bit = ~a_sr[0];
        y_nxt   = {res_bit, y[N-1:1]};
      end
      OP_SHL: y_nxt = {y[N-2:0], 1'b0};
      OP_SHR: y_nxt = {1'b0, y[N-1:1]};
      OP_MUL: begin
`ifdef ALU_MUL_EN
        // y holds the multiplier bits still to be consumed (LSB first);
        // the product grows down from y_ext into y as it shifts right.
        mul_sum   = {1'b0, y_ext} + (y[0] ? {1'b0, a_sr} : '0);
        y_ext_nxt = mul_sum[N:1];
        y_nxt     = {mul_sum[0], y[N-1:1]};
`endif
      end
      default: ;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      y     <= '0;
      y_ext <= '0;
      ovf   <= 1'b0;
    end else if (inp) begin
      a_sr  <= a;
      b_sr  <= (opcode == OP_SUB) ? ~b : b;
      op_r  <= opcode;
      carry <= (opcode == OP_SUB);
      cnt   <= CW'(N);
      busy  <= 1'b1;
      ovf   <= 1'b0;
      y_ext <= '0;
      case (opcode)
        OP_SHL, OP_SHR: y <= a;
`ifdef ALU_MUL_EN
        OP_MUL:         y <= b;
`endif
        default:        y <= '0;
      endcase
    end else if (busy) begin
      cnt   <= cnt - CW'(1);
      if (last_step) busy <= 1'b0;
      // The multiplicand must stay put; every other op consumes A/B LSB first.
      if (op_r != OP_MUL) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
      end
      carry <= carry_nxt;
      y     <= y_nxt;
      y_ext <= y_ext_nxt;
      if (last_step && op_r == OP_ADD) ovf <= carry_nxt;
      if (last_step && op_r == OP_SUB) ovf <= ~carry_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  localparam int N = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inp = 1'b0;
  logic [2:0]   opcode = '0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] y;
  logic [N-1:0] y_ext;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  alu #(.N(N)) dut (
    .inp    (inp),
    .clk    (clk),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .y_ext  (y_ext),
    .y      (y),
    .ovf    (ovf),
    .rst    (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic int ref_y(input int op, input int av, input int bv);
    case (op)
      0: return (av + bv) & MASK;
      1: return (av - bv) & MASK;
      2: return av & bv;
      3: return av | bv;
      4: return (~av) & MASK;
      5: return 0;
      6: return 0;
`ifdef ALU_MUL_EN
      7: return (av * bv) & MASK;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic int ref_y_ext(input int op, input int av, input int bv);
`ifdef ALU_MUL_EN
    if (op == 7) return (av * bv) >> N;
`endif
    return 0;
  endfunction

  function automatic int ref_ovf(input int op, input int av, input int bv);
    if (op == 0) return ((av + bv) >> N) & 1;
    if (op == 1) return (av < bv) ? 1 : 0;
    return 0;
  endfunction

  task automatic start(input int op, input int av, input int bv);
    @(negedge clk);
    opcode = op[2:0];
    a      = av[N-1:0];
    b      = bv[N-1:0];
    inp    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inp    = 1'b0;
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_final(input string tag, input int op, input int av, input int bv);
    check({tag, ".y"},     32'(y),     32'(ref_y(op, av, bv)));
    check({tag, ".y_ext"}, 32'(y_ext), 32'(ref_y_ext(op, av, bv)));
    check({tag, ".ovf"},   32'(ovf),   32'(ref_ovf(op, av, bv)));
  endtask

  // Full operation: start, N steps (shift intermediates checked), final check,
  // then verify the result holds while idle.
  task automatic run_op(input string tag, input int op, input int av, input int bv);
    start(op, av, bv);
    for (int k = 1; k <= N; k++) begin
      step_n(1);
      if (op == 5) check($sformatf("%s.shl_k%0d", tag, k), 32'(y), 32'((av << k) & MASK));
      if (op == 6) check($sformatf("%s.shr_k%0d", tag, k), 32'(y), 32'((av >> k) & MASK));
    end
    check_final(tag, op, av, bv);
    step_n(3);
    check({tag, ".hold_y"}, 32'(y), 32'(ref_y(op, av, bv)));
  endtask

  initial begin
    // Reset state.
    step_n(2);
    check("rst.y", 32'(y), 32'd0);
    check("rst.y_ext", 32'(y_ext), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_op("add_5_13", 0, 5, 13);
    run_op("sub_5_13", 1, 5, 13);
    run_op("sub_13_5", 1, 13, 5);
    run_op("sub_eq", 1, 7, 7);
    run_op("and", 2, 5, 13);
    run_op("or", 3, 5, 13);
    run_op("not", 4, 5, 13);
    run_op("shl", 5, 5, 0);
    run_op("shr", 6, 5, 0);
    run_op("mul_5_13", 7, 5, 13);
    run_op("mul_15_15", 7, 15, 15);
    run_op("add_max", 0, 15, 15);
    run_op("add_zero", 0, 0, 0);

    // Reset in the middle of an add: cleared and idle afterwards.
    start(0, 5, 13);
    step_n(2);
    rst = 1'b1;
    step_n(1);
    rst = 1'b0;
    check("midrst.y", 32'(y), 32'd0);
    check("midrst.y_ext", 32'(y_ext), 32'd0);
    check("midrst.ovf", 32'(ovf), 32'd0);
    step_n(N + 1);
    check("midrst_idle.y", 32'(y), 32'd0);
    check("midrst_idle.ovf", 32'(ovf), 32'd0);

    // Restart while busy: only the new operands count.
    start(0, 5, 13);
    step_n(1);
    start(1, 9, 3);
    step_n(N);
    check_final("restart", 1, 9, 3);

    // inp held high for two edges: the last captured operands win.
    @(negedge clk);
    opcode = 3'b000; a = 4'd1; b = 4'd2; inp = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'd7; b = 4'd8;
    @(posedge clk);
    @(negedge clk);
    inp = 1'b0;
    step_n(N);
    check_final("held_inp", 0, 7, 8);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      int op, av, bv;
      op = int'($urandom_range(0, 7));
      av = int'($urandom_range(0, MASK));
      bv = int'($urandom_range(0, MASK));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, av, bv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
